// File: rtl/stage4_defast_message_demux_pkg.sv
// Shared constants and types for the stage-4 defast message demux.
//   - message word / tag widths and the idle register value
//   - field tag codes (a, d, k, q, N); codes above TAG_N are invalid
//   - per-lane FSM state encoding
package stage4_defast_message_demux_pkg;

  localparam int unsigned MAX_MESSAGE_BITS          = 64;
  localparam int unsigned MESSAGE_MUX_CONTROL_WIDTH = 3;
  localparam int unsigned DEFAUT_MESSAGE            = 0;
  localparam int unsigned NUM_FIELDS                = 5;

  typedef enum logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] {
    TAG_A = 3'd0,
    TAG_D = 3'd1,
    TAG_K = 3'd2,
    TAG_Q = 3'd3,
    TAG_N = 3'd4
  } msg_tag_e;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } lane_state_e;

endpackage

// File: rtl/stage4_defast_message_demux_if.sv
// One demux lane's bus bundle.
//   source side : message, message_tag, message_valid -> message_ready
//   sink side   : message_a/d/k/q/N, set_valid       <- set_ready
//   status      : tag_err, dup_err (sticky)
// slave modport is the demux view, master modport is the source/consumer view.
interface stage4_defast_message_demux_if
  import stage4_defast_message_demux_pkg::*;
#(
  parameter int unsigned MSG_W = MAX_MESSAGE_BITS,
  parameter int unsigned TAG_W = MESSAGE_MUX_CONTROL_WIDTH
);
  logic [MSG_W-1:0] message;
  logic [TAG_W-1:0] message_tag;
  logic             message_valid;
  logic             message_ready;
  logic [MSG_W-1:0] message_a;
  logic [MSG_W-1:0] message_d;
  logic [MSG_W-1:0] message_k;
  logic [MSG_W-1:0] message_q;
  logic [MSG_W-1:0] message_N;
  logic             set_valid;
  logic             set_ready;
  logic             tag_err;
  logic             dup_err;

  modport slave (
    input  message, message_tag, message_valid, set_ready,
    output message_ready, message_a, message_d, message_k, message_q,
           message_N, set_valid, tag_err, dup_err
  );

  modport master (
    output message, message_tag, message_valid, set_ready,
    input  message_ready, message_a, message_d, message_k, message_q,
           message_N, set_valid, tag_err, dup_err
  );
endinterface

// File: rtl/stage4_defast_message_demux_lane.sv
// One demux lane: steers tagged words into five field registers, then holds
// the complete set for the downstream datapath until set_ready.
//   clk, rst (sync, active-high), err_clr (clears sticky errors)
//   lane : slave view of the lane bundle
// All lane outputs come straight from flops.
module stage4_defast_message_demux_lane
  import stage4_defast_message_demux_pkg::*;
#(
  parameter int unsigned      MSG_W       = MAX_MESSAGE_BITS,
  parameter int unsigned      TAG_W       = MESSAGE_MUX_CONTROL_WIDTH,
  parameter logic [MSG_W-1:0] DEFAULT_MSG = MSG_W'(DEFAUT_MESSAGE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          err_clr,
  stage4_defast_message_demux_if.slave  lane
);

  lane_state_e           state_q, state_d;
  logic [NUM_FIELDS-1:0] mask_q, mask_d;
  logic [MSG_W-1:0]      fields_q [NUM_FIELDS];
  logic [MSG_W-1:0]      fields_d [NUM_FIELDS];
  logic                  ready_q, ready_d;
  logic                  set_valid_q, set_valid_d;
  logic                  tag_err_q, tag_err_d;
  logic                  dup_err_q, dup_err_d;
  logic                  accept;
  logic                  tag_hit;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    fields_d    = fields_q;
    ready_d     = ready_q;
    set_valid_d = set_valid_q;
    tag_hit     = 1'b0;
    accept      = lane.message_valid & ready_q & (state_q == COLLECT);
    // A new error in the same cycle as err_clr wins: clear first, then OR in.
    tag_err_d   = tag_err_q & ~err_clr;
    dup_err_d   = dup_err_q & ~err_clr;

    unique case (state_q)
      COLLECT: begin
        ready_d     = 1'b1;
        set_valid_d = 1'b0;
        if (accept) begin
          for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (lane.message_tag == TAG_W'(i)) begin
              tag_hit     = 1'b1;
              fields_d[i] = lane.message;
              mask_d[i]   = 1'b1;
              if (mask_q[i]) dup_err_d = 1'b1;
            end
          end
          if (!tag_hit) tag_err_d = 1'b1;
          if (mask_d == '1) begin
            state_d     = HOLD;
            ready_d     = 1'b0;
            set_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        ready_d     = 1'b0;
        set_valid_d = 1'b1;
        if (lane.set_ready) begin
          state_d     = COLLECT;
          mask_d      = '0;
          ready_d     = 1'b1;
          set_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      mask_q      <= '0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++) fields_q[i] <= DEFAULT_MSG;
      ready_q     <= 1'b0;
      set_valid_q <= 1'b0;
      tag_err_q   <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      fields_q    <= fields_d;
      ready_q     <= ready_d;
      set_valid_q <= set_valid_d;
      tag_err_q   <= tag_err_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign lane.message_ready = ready_q;
  assign lane.set_valid     = set_valid_q;
  assign lane.tag_err       = tag_err_q;
  assign lane.dup_err       = dup_err_q;
  assign lane.message_a     = fields_q[TAG_A];
  assign lane.message_d     = fields_q[TAG_D];
  assign lane.message_k     = fields_q[TAG_K];
  assign lane.message_q     = fields_q[TAG_Q];
  assign lane.message_N     = fields_q[TAG_N];

endmodule

// File: rtl/stage4_defast_message_demux.sv
// Stage-4 defast message demux: three independent lanes that turn tagged
// message streams back into complete a/d/k/q/N operand sets.
//   clk, rst (sync, active-high), err_clr (clears every lane's sticky errors)
//   lane_1, lane_2, lane_3 : slave views of the per-lane bundles
module stage4_defast_message_demux
  import stage4_defast_message_demux_pkg::*;
#(
  parameter int unsigned      MSG_W       = MAX_MESSAGE_BITS,
  parameter int unsigned      TAG_W       = MESSAGE_MUX_CONTROL_WIDTH,
  parameter logic [MSG_W-1:0] DEFAULT_MSG = MSG_W'(DEFAUT_MESSAGE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          err_clr,
  stage4_defast_message_demux_if.slave  lane_1,
  stage4_defast_message_demux_if.slave  lane_2,
  stage4_defast_message_demux_if.slave  lane_3
);

  stage4_defast_message_demux_lane #(
    .MSG_W       (MSG_W),
    .TAG_W       (TAG_W),
    .DEFAULT_MSG (DEFAULT_MSG)
  ) u_lane_1 (
    .clk     (clk),
    .rst     (rst),
    .err_clr (err_clr),
    .lane    (lane_1)
  );

  stage4_defast_message_demux_lane #(
    .MSG_W       (MSG_W),
    .TAG_W       (TAG_W),
    .DEFAULT_MSG (DEFAULT_MSG)
  ) u_lane_2 (
    .clk     (clk),
    .rst     (rst),
    .err_clr (err_clr),
    .lane    (lane_2)
  );

  stage4_defast_message_demux_lane #(
    .MSG_W       (MSG_W),
    .TAG_W       (TAG_W),
    .DEFAULT_MSG (DEFAULT_MSG)
  ) u_lane_3 (
    .clk     (clk),
    .rst     (rst),
    .err_clr (err_clr),
    .lane    (lane_3)
  );

endmodule
